// File: rtl/fifo4x16_pkg.sv
// rtl/fifo4x16_pkg.sv - shared sizes and types for the 4-entry, 16-bit FIFO
package fifo4x16_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

endpackage

// File: rtl/and16.sv
// rtl/and16.sv - bitwise AND of two 16-bit words
module and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  assign out = a & b;

endmodule

// File: rtl/mux4way16.sv
// rtl/mux4way16.sv - 4-input, 16-bit word multiplexer
module mux4way16 (
  input  logic [15:0] i0,
  input  logic [15:0] i1,
  input  logic [15:0] i2,
  input  logic [15:0] i3,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // select one of four words
  always_comb begin
    out = i0;
    case (sel)
      2'd0: out = i0;
      2'd1: out = i1;
      2'd2: out = i2;
      2'd3: out = i3;
      default: out = i0;
    endcase
  end

endmodule

// File: rtl/fifo4x16.sv
// rtl/fifo4x16.sv - 4-entry show-ahead FIFO with sticky overflow/underflow flags
module fifo4x16
  import fifo4x16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  word_t mem [DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  logic  push_ok;
  logic  pop_ok;
  word_t head;
  word_t empty_mask;

  // Status comes from the registered count only, so push/pop never reach full/empty.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Accept decisions: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Pointers and occupancy; pointers wrap naturally at 2 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (push_ok && !pop_ok)      count <= count + cnt_t'(1);
      else if (pop_ok && !push_ok) count <= count - cnt_t'(1);
    end
  end

  // Storage write; contents are not cleared since out is masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= in;
  end

  // Sticky error flags; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (pop && !pop_ok)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  mux4way16 u_rd_mux (
    .i0  (mem[0]),
    .i1  (mem[1]),
    .i2  (mem[2]),
    .i3  (mem[3]),
    .sel (rd_ptr),
    .out (head)
  );

  assign empty_mask = {WIDTH{~empty}};

  and16 u_rd_mask (
    .a   (head),
    .b   (empty_mask),
    .out (out)
  );

endmodule

// File: tb/tb_fifo4x16.sv
// tb/tb_fifo4x16.sv - self-checking bench for fifo4x16
module tb_fifo4x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        push;
  logic        pop;
  logic        clr_err;
  logic [15:0] out;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int compared   = 0;
  int mismatched = 0;

  // reference model: plain queue of words plus two flags
  logic [15:0] mq[$];
  logic        m_ovf;
  logic        m_udf;

  typedef struct {
    logic        rst;
    logic        pu;
    logic        po;
    logic        cl;
    logic [15:0] din;
    logic [15:0] eout;
    logic [2:0]  ecnt;
    logic        efull;
    logic        eempty;
    logic        eovf;
    logic        eudf;
  } vec_t;

  vec_t vecs[$];

  fifo4x16 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .out       (out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic pu, input logic po, input logic cl,
                             input logic [15:0] din, input logic [15:0] eout, input logic [2:0] ecnt,
                             input logic efull, input logic eempty, input logic eovf, input logic eudf);
    vec_t r;
    r.rst = rst; r.pu = pu; r.po = po; r.cl = cl; r.din = din;
    r.eout = eout; r.ecnt = ecnt; r.efull = efull; r.eempty = eempty;
    r.eovf = eovf; r.eudf = eudf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] eout, input logic [2:0] ecnt,
                           input logic efull, input logic eempty, input logic eovf, input logic eudf);
    chk({tag, ".out"},       out,               eout);
    chk({tag, ".count"},     {13'd0, count},    {13'd0, ecnt});
    chk({tag, ".full"},      {15'd0, full},     {15'd0, efull});
    chk({tag, ".empty"},     {15'd0, empty},    {15'd0, eempty});
    chk({tag, ".overflow"},  {15'd0, overflow}, {15'd0, eovf});
    chk({tag, ".underflow"}, {15'd0, underflow},{15'd0, eudf});
  endtask

  // model update from the queue rules: pop takes the head, push appends if room (after the pop)
  task automatic model_step(input logic rst, input logic pu, input logic po, input logic cl,
                            input logic [15:0] din);
    bit pa, pw;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pa = po && (mq.size() > 0);
      pw = pu && ((mq.size() < 4) || pa);
      if (pa) void'(mq.pop_front());
      if (pw) mq.push_back(din);
      if (pu && !pw) m_ovf = 1'b1; else if (cl) m_ovf = 1'b0;
      if (po && !pa) m_udf = 1'b1; else if (cl) m_udf = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic pu, input logic po, input logic cl,
                      input logic [15:0] din);
    reset = rst; push = pu; pop = po; clr_err = cl; in = din;
    @(posedge clk);
    model_step(rst, pu, po, cl, din);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eo;
    int n;
    n  = mq.size();
    eo = (n > 0) ? mq[0] : 16'h0000;
    check_all(tag, eo, 3'(n), n == 4, n == 0, m_ovf, m_udf);
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; in = 16'h0;
    m_ovf = 1'b0; m_udf = 1'b0;

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // table: rst pu po cl din | out cnt full empty ovf udf
    vecs.push_back(v(0,1,0,0,16'hA001, 16'hA001,3'd1,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'hA002, 16'hA001,3'd2,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'hA003, 16'hA001,3'd3,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'hA004, 16'hA001,3'd4,1,0,0,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'hA002,3'd3,0,0,0,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'hA003,3'd2,0,0,0,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'hA004,3'd1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'h0000,3'd0,0,1,0,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'h0000,3'd0,0,1,0,1));
    vecs.push_back(v(0,0,0,1,16'h0000, 16'h0000,3'd0,0,1,0,0));
    vecs.push_back(v(0,1,1,0,16'h1234, 16'h1234,3'd1,0,0,0,1));
    vecs.push_back(v(0,0,0,1,16'h0000, 16'h1234,3'd1,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'h2222, 16'h1234,3'd2,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'h3333, 16'h1234,3'd3,0,0,0,0));
    vecs.push_back(v(0,1,0,0,16'h4444, 16'h1234,3'd4,1,0,0,0));
    vecs.push_back(v(0,1,0,0,16'hFFFF, 16'h1234,3'd4,1,0,1,0));
    vecs.push_back(v(0,1,0,1,16'hFFFF, 16'h1234,3'd4,1,0,1,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'h2222,3'd3,0,0,1,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'h3333,3'd2,0,0,1,0));
    vecs.push_back(v(0,0,1,0,16'h0000, 16'h4444,3'd1,0,0,1,0));
    vecs.push_back(v(1,1,1,1,16'h5555, 16'h0000,3'd0,0,1,0,0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].pu, vecs[i].po, vecs[i].cl, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].eout, vecs[i].ecnt, vecs[i].efull,
                vecs[i].eempty, vecs[i].eovf, vecs[i].eudf);
    end

    // full with read pointer at 2, then simultaneous push/pop across the wrap
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0222);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hC001);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hC002);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hC003);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hC004);
    check_all("wrap.fill", 16'hC001, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    check_all("wrap.pp1", 16'hC002, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    check_all("wrap.pp2", 16'hC003, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    check_all("wrap.pp3", 16'hC004, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    check_all("wrap.pp4", 16'hBEEF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      check_model($sformatf("wrap.drain%0d", k));
    end
    check_all("wrap.empty", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset in the middle of traffic discards contents
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h8888);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check_all("midreset", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      logic r_rst, r_pu, r_po, r_cl;
      r_rst = ($urandom_range(0, 39) == 0);
      r_pu  = ($urandom_range(0, 99) < 55);
      r_po  = ($urandom_range(0, 99) < 50);
      r_cl  = ($urandom_range(0, 7) == 0);
      step(r_rst, r_pu, r_po, r_cl, 16'($urandom));
      check_model($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
